mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle control unit and instruction sequencer for the Lab3 MIPS subset. It fetches an instruction,
//  decodes it, and drives the ALU's opcode/funct inputs and every datapath strobe. It reads alu_zero and
//  alu_overflow back and handshakes with instruction and data memory. It issues the ALU command stream.
//  It sits between the memories and the datapath (regfile, PC, ALU).
// PARAMETERS
//  RESET_PC_SEL  2'd0  pc_sel value driven while idle/trapped (no PC write occurs)
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  rst_n         in   1   reset, asynchronous, active-low
//  imem_rdata    in   32  instruction word; valid when imem_ack=1
//  imem_ack      in   1   instruction memory done; only sampled in FETCH
//  dmem_ack      in   1   data memory done; only sampled in MEM
//  alu_zero      in   1   ALU zero flag, sampled in EXEC
//  alu_overflow  in   1   ALU signed overflow, sampled in EXEC
//  imem_req      out  1   instruction fetch request (level, held until ack)
//  dmem_req      out  1   data access request (level, held until ack)
//  dmem_we       out  1   1=store, qualifies dmem_req
//  ir            out  32  instruction register
//  alu_opcode    out  6   to ALU opcode input
//  alu_funct     out  6   to ALU funct input
//  reg_we        out  1   regfile write strobe (one cycle)
//  reg_dst       out  2   0=rt, 1=rd, 2=r31
//  wb_sel        out  2   0=ALU result, 1=dmem read data, 2=PC+4
//  pc_we         out  1   PC write strobe (one cycle)
//  pc_sel        out  2   0=PC+4, 1=branch target, 2=jump target, 3=rs (JR)
//  trap          out  1   sticky: illegal instruction or arithmetic overflow
// BEHAVIOUR
//  - Supported: LW 100011, SW 101011, J 000010, JAL 000011, BEQ 000100, BNE 000101, XORI 001110,
//    ADDI 001000, R-type 000000 with funct JR 001000, ADD 100000, SUB 100010, SLT 101010.
//  - States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore, decoded from state + ir.
//  - Reset: state=IDLE, ir=0, trap=0. All strobes and requests are 0. alu_opcode=000000, alu_funct=100000.
//    Reset mid-operation abandons the instruction at once; a pending req drops asynchronously.
//  - IDLE: all strobes 0. Goes to FETCH unconditionally, so first imem_req=1 is 1 cycle after rst_n rises.
//  - FETCH: imem_req=1 until imem_ack. On ack, ir<=imem_rdata and the state goes to DECODE.
//  - DECODE: illegal opcode or funct -> TRAP. J -> pc_we, pc_sel=2, then FETCH.
//    JAL -> reg_we, reg_dst=2, wb_sel=2, pc_we, pc_sel=2, then FETCH. All others go to EXEC.
//  - EXEC: alu_opcode=ir[31:26], alu_funct=ir[5:0].
//    BEQ: pc_we with pc_sel=alu_zero?1:0. BNE: pc_we with pc_sel=alu_zero?0:1. Both then go to FETCH.
//    JR: pc_we, pc_sel=3, then FETCH. LW/SW go to MEM.
//    ADD/SUB/ADDI with alu_overflow=1 -> TRAP; no reg_we for that instruction.
//    Otherwise ADD/SUB/SLT/ADDI/XORI go to WB.
//  - MEM: dmem_req=1, dmem_we=(SW); ALU fields held from ir. Stays until dmem_ack.
//    On ack, SW gets pc_we with pc_sel=0 and goes to FETCH; LW goes to WB.
//  - WB: reg_we=1 for exactly one cycle; ALU fields still driven from ir.
//    reg_dst=1 for R-type, else 0. wb_sel=1 for LW, else 0. pc_we with pc_sel=0, then FETCH.
//  - Outside EXEC/MEM/WB the ALU fields are 000000/100000 (ADD), so the ALU never sees an undefined command.
//  - TRAP: terminal. trap=1, all strobes 0, pc_sel=RESET_PC_SEL. Only rst_n leaves it.
//  - An ack arriving outside its own state is ignored. Ack in the first request cycle is legal (no extra wait).
//  - Exactly one pc_we pulse per retired instruction; at most one reg_we.
//  - Latency with zero-wait memory: J/JAL 2, BEQ/BNE/JR 3, R-type/ADDI/XORI/SW 4, LW 5 cycles.
// STRUCTURE
//  - Shared header mips_defs.vh: opcode/funct `defines, state encodings, pc_sel/wb_sel/reg_dst encodings.
//    The ALU uses the same opcode/funct `defines.
//  - One sub-module, mips_instr_class: combinational ir -> {legal, is_rtype, is_branch, is_mem, is_jump,
//    checks_ovf}, instantiated once.
//  - FSM state register and ir are the only flops besides trap.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles, release -> IDLE 1 cycle, imem_req=1 next cycle, all strobes 0 before that.
//  2 ADD r3,r1,r2 (0x00221820), ack same cycle -> EXEC shows alu_opcode 000000/alu_funct 100000;
//    WB has reg_we=1, reg_dst=1, pc_sel=0; next instruction fetched on cycle 5.
//  3 LW (0x8C220004) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0;
//    reg_we with wb_sel=1 one cycle after ack.
//  4 BEQ (0x10220003): alu_zero=1 -> pc_sel=1; alu_zero=0 -> pc_sel=0. BNE gives the inverse. No reg_we.
//  5 JAL (0x0C000010) -> in DECODE: reg_we, reg_dst=2, wb_sel=2, pc_sel=2; no EXEC cycle.
//  6 Opcode 0x3F, or ADDI with alu_overflow=1 -> trap=1 and sticky, no reg_we/pc_we;
//    assert rst_n=0 mid-MEM -> dmem_req drops at once.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Holds the opcode/funct encodings (also used by the ALU), the FSM state
// encoding and the pc_sel / wb_sel / reg_dst mux encodings.
package mips_multicycle_ctrl_pkg;

   // Primary opcodes, ir[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes, ir[5:0]
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU command presented whenever no instruction owns the ALU (plain ADD)
   localparam logic [5:0] ALU_IDLE_OPCODE = OP_RTYPE;
   localparam logic [5:0] ALU_IDLE_FUNCT  = FN_ADD;

   // pc_sel encodings
   localparam logic [1:0] PC_SEL_PC4    = 2'd0;
   localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
   localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
   localparam logic [1:0] PC_SEL_RS     = 2'd3;

   // wb_sel encodings
   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   // reg_dst encodings
   localparam logic [1:0] REG_DST_RT  = 2'd0;
   localparam logic [1:0] REG_DST_RD  = 2'd1;
   localparam logic [1:0] REG_DST_R31 = 2'd2;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } stateT;

endpackage

// File: rtl/mips_instr_class.sv
// Combinational instruction classifier.
// Ports:
//   opcode    in  6  ir[31:26]
//   funct     in  6  ir[5:0]
//   legal     out 1  instruction is in the supported subset
//   isRtype   out 1  opcode 000000 (destination is rd)
//   isBranch  out 1  BEQ or BNE
//   isMem     out 1  LW or SW
//   isJump    out 1  J or JAL (resolved in DECODE; JR is R-type and resolved in EXEC)
//   checksOvf out 1  ADD, SUB or ADDI: signed overflow traps
module mips_instr_class
   import mips_multicycle_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic       legal,
   output logic       isRtype,
   output logic       isBranch,
   output logic       isMem,
   output logic       isJump,
   output logic       checksOvf
);

   always_comb begin
      legal     = 1'b0;
      isRtype   = (opcode == OP_RTYPE);
      isBranch  = 1'b0;
      isMem     = 1'b0;
      isJump    = 1'b0;
      checksOvf = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_JR, FN_SLT: legal = 1'b1;
               FN_ADD, FN_SUB: begin
                  legal     = 1'b1;
                  checksOvf = 1'b1;
               end
               default: legal = 1'b0;
            endcase
         end
         OP_J, OP_JAL: begin
            legal  = 1'b1;
            isJump = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            legal    = 1'b1;
            isBranch = 1'b1;
         end
         OP_ADDI: begin
            legal     = 1'b1;
            checksOvf = 1'b1;
         end
         OP_XORI: legal = 1'b1;
         OP_LW, OP_SW: begin
            legal = 1'b1;
            isMem = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control unit / instruction sequencer for the Lab3 MIPS subset.
// Fetches, decodes and sequences each instruction, driving the ALU command
// and every datapath strobe. Outputs are Moore-decoded from state + ir, with
// the branch direction (alu_zero) and the store completion (dmem_ack) folded
// into the same cycle's pc_we/pc_sel.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_rdata/imem_ack   instruction word and fetch completion
//   dmem_ack              data access completion
//   alu_zero/alu_overflow ALU flags, used in EXEC only
//   imem_req              fetch request
//   dmem_req/dmem_we      data access request, dmem_we=1 for store
//   ir                    instruction register
//   alu_opcode/alu_funct  ALU command
//   reg_we/reg_dst/wb_sel regfile write strobe, destination and source
//   pc_we/pc_sel          PC write strobe and next-PC source
//   trap                  sticky illegal-instruction / overflow flag
//   dbgState              current sequencer state (stateT encoding)
//
// Memory handshake: a request (imem_req / dmem_req) is a level held high for
// as long as the sequencer sits in FETCH / MEM. The transfer completes on the
// rising edge where the request and its ack are both 1; an ack may come in the
// very first request cycle. An ack seen while its request is low is ignored.
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        alu_zero,
   input  logic        alu_overflow,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] ir,
   output logic [5:0]  alu_opcode,
   output logic [5:0]  alu_funct,
   output logic        reg_we,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wb_sel,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        trap,
   output logic [2:0]  dbgState
);

   stateT      state;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       legal;
   logic       isRtype;
   logic       isBranch;
   logic       isMem;
   logic       isJump;
   logic       checksOvf;
   logic       isJr;
   logic       isStore;

   assign opcode   = ir[31:26];
   assign funct    = ir[5:0];
   assign isJr     = isRtype && (funct == FN_JR);
   assign isStore  = (opcode == OP_SW);
   assign dbgState = state;

   mips_instr_class uClass (
      .opcode    (opcode),
      .funct     (funct),
      .legal     (legal),
      .isRtype   (isRtype),
      .isBranch  (isBranch),
      .isMem     (isMem),
      .isJump    (isJump),
      .checksOvf (checksOvf)
   );

   // State, ir and trap are the only storage; trap is set on the same edge
   // that enters ST_TRAP so it is high for every cycle spent there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ir    <= '0;
         trap  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_FETCH;
            ST_FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_rdata;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (!legal) begin
                  state <= ST_TRAP;
                  trap  <= 1'b1;
               end else if (isJump) begin
                  state <= ST_FETCH;
               end else begin
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (checksOvf && alu_overflow) begin
                  state <= ST_TRAP;
                  trap  <= 1'b1;
               end else if (isBranch || isJr) begin
                  state <= ST_FETCH;
               end else if (isMem) begin
                  state <= ST_MEM;
               end else begin
                  state <= ST_WB;
               end
            end
            ST_MEM: begin
               if (dmem_ack) state <= isStore ? ST_FETCH : ST_WB;
            end
            ST_WB:   state <= ST_FETCH;
            ST_TRAP: state <= ST_TRAP;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = REG_DST_RT;
      wb_sel     = WB_SEL_ALU;
      pc_we      = 1'b0;
      pc_sel     = PC_SEL_PC4;
      alu_opcode = ALU_IDLE_OPCODE;
      alu_funct  = ALU_IDLE_FUNCT;
      case (state)
         ST_IDLE:  pc_sel = RESET_PC_SEL;
         ST_FETCH: imem_req = 1'b1;
         ST_DECODE: begin
            if (legal && isJump) begin
               pc_we  = 1'b1;
               pc_sel = PC_SEL_JUMP;
               if (opcode == OP_JAL) begin
                  reg_we  = 1'b1;
                  reg_dst = REG_DST_R31;
                  wb_sel  = WB_SEL_PC4;
               end
            end
         end
         ST_EXEC: begin
            alu_opcode = opcode;
            alu_funct  = funct;
            if (isBranch) begin
               // BNE takes the branch on the inverted zero flag
               pc_we  = 1'b1;
               pc_sel = (alu_zero ^ (opcode == OP_BNE)) ? PC_SEL_BRANCH : PC_SEL_PC4;
            end else if (isJr) begin
               pc_we  = 1'b1;
               pc_sel = PC_SEL_RS;
            end
         end
         ST_MEM: begin
            alu_opcode = opcode;
            alu_funct  = funct;
            dmem_req   = 1'b1;
            dmem_we    = isStore;
            // A store retires in MEM; a load retires later in WB
            if (dmem_ack && isStore) pc_we = 1'b1;
         end
         ST_WB: begin
            alu_opcode = opcode;
            alu_funct  = funct;
            reg_we     = 1'b1;
            reg_dst    = isRtype ? REG_DST_RD : REG_DST_RT;
            wb_sel     = (opcode == OP_LW) ? WB_SEL_MEM : WB_SEL_ALU;
            pc_we      = 1'b1;
         end
         ST_TRAP: pc_sel = RESET_PC_SEL;
         default: pc_sel = PC_SEL_PC4;
      endcase
   end

endmodule
